// File: rtl/tile_accum.sv
// tile_accum: sums the fp16 chunk partials of one dot product into a single fp16 result.
// Latency: a last chunk issued in cycle t gives out_valid in cycle t+LATENCY+1.
// Backpressure: in_ready falls once queued plus in-flight results would exceed the 2-entry output FIFO.
// Optional feature: define TILE_ACCUM_NAN_FLAG_EN to add the out_nan flag per result.

// Small generic FIFO: registered storage, push and pop in the same cycle both take effect.
// Latency: data pushed in cycle t is visible at rd_dat in cycle t+1.
// Backpressure: a push while full without a pop is dropped; full is exported for the caller.
module tile_accum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign rd_vld = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_vld && rd_rdy;
  assign do_wr  = wr_vld && (!full || do_rd);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end
endmodule

module tile_accum #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_scal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
`ifdef TILE_ACCUM_NAN_FLAG_EN
  ,
  output logic              out_nan
`endif
);
  localparam int OCC_W = $clog2(LATENCY + 3);
`ifdef TILE_ACCUM_NAN_FLAG_EN
  localparam int E_W = DATA_W + CNT_W + 1;
`else
  localparam int E_W = DATA_W + CNT_W;
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  // IEEE binary16 add, round to nearest even; any NaN input gives the quiet NaN 0x7E00.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [10:0] mx, my;
    logic [4:0]  ex, ey, d;
    logic [13:0] ax, ay;
    logic [14:0] s;
    logic [6:0]  e;
    logic [11:0] m;
    logic        sticky, inc;
    r = '0; x = a; y = b; s = '0; e = '0; m = '0; ay = '0; sticky = 1'b0; inc = 1'b0;
    if ((&a[14:10] && |a[9:0]) || (&b[14:10] && |b[9:0])) r = 16'h7E00;
    else if (&a[14:10]) r = (&b[14:10] && (a[15] != b[15])) ? 16'h7E00 : a;
    else if (&b[14:10]) r = b;
    else begin
      // Larger magnitude goes in x so the aligned difference never goes negative.
      if (a[14:0] < b[14:0]) begin x = b; y = a; end
      ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
      mx = {x[14:10] != 5'd0, x[9:0]};
      my = {y[14:10] != 5'd0, y[9:0]};
      d  = ex - ey;
      ax = {mx, 3'b000};
      if (d > 5'd13) begin
        ay = '0;
        sticky = (my != '0);
      end else begin
        ay = {my, 3'b000} >> d;
        sticky = |({my, 3'b000} & ((14'd1 << d) - 14'd1));
      end
      ay = ay | {13'd0, sticky};
      s  = (x[15] == y[15]) ? ({1'b0, ax} + {1'b0, ay}) : ({1'b0, ax} - {1'b0, ay});
      e  = {2'b00, ex};
      if (s == '0) r = {x[15] & y[15], 15'd0};
      else begin
        if (s[14]) begin
          s = {1'b0, s[14:1]} | {14'd0, s[0]};
          e = e + 7'd1;
        end else begin
          // Normalise left, stopping at the subnormal exponent.
          for (int i = 0; i < 13; i++)
            if (!s[13] && (e > 7'd1)) begin
              s = s << 1;
              e = e - 7'd1;
            end
        end
        inc = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[13:3]} + {11'd0, inc};
        if (m[11]) begin
          m = m >> 1;
          e = e + 7'd1;
        end
        if (e >= 7'd31) r = {x[15], 5'h1F, 10'd0};
        else            r = {x[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
      end
    end
    return r;
  endfunction

  logic [LATENCY-1:0] sh_vld, sh_last;
  logic [OCC_W-1:0]   lasts_in_flight;
  logic               issue, arrive, arr_last;
  state_t             state;
  logic [DATA_W-1:0]  acc, sum;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic               push, fifo_full;
  logic [E_W-1:0]     push_dat, pop_dat;
  logic [1:0]         fifo_cnt;
`ifdef TILE_ACCUM_NAN_FLAG_EN
  logic               nan_acc, scal_nan;
  assign scal_nan = (&in_scal[14:10]) && (|in_scal[9:0]);
`endif

  assign issue    = in_valid && in_ready;
  assign arrive   = sh_vld[LATENCY-1];
  assign arr_last = sh_last[LATENCY-1];
  assign busy     = (state == ACCUM) || (|sh_vld);

  // Count last beats still travelling through the tile; each will claim a FIFO slot.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i < LATENCY; i++) lasts_in_flight = lasts_in_flight + OCC_W'(sh_last[i]);
    in_ready = (OCC_W'(fifo_cnt) + lasts_in_flight) < OCC_W'(2);
  end

  // Non-stallable delay line mirroring the tile pipeline; last is only kept for valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_vld  <= '0;
      sh_last <= '0;
    end else begin
      sh_vld[0]  <= issue;
      sh_last[0] <= issue && in_last;
      for (int i = 1; i < LATENCY; i++) begin
        sh_vld[i]  <= sh_vld[i-1];
        sh_last[i] <= sh_last[i-1];
      end
    end
  end

  // Result formation for a last arrival: bypass when idle, otherwise fold in the final partial.
  always_comb begin
    sum      = fp16_add(acc, in_scal);
    cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    push     = arrive && arr_last;
    push_dat = '0;
    if (push) begin
`ifdef TILE_ACCUM_NAN_FLAG_EN
      if (state == IDLE) push_dat = {in_scal, CNT_W'(1), scal_nan};
      else               push_dat = {sum, cnt_inc, nan_acc | scal_nan};
`else
      if (state == IDLE) push_dat = {in_scal, CNT_W'(1)};
      else               push_dat = {sum, cnt_inc};
`endif
    end
  end

  // Accumulator FSM: IDLE holds nothing, ACCUM holds a partial sum and its chunk count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
`ifdef TILE_ACCUM_NAN_FLAG_EN
      nan_acc <= 1'b0;
`endif
    end else if (arrive) begin
      if (arr_last) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
`ifdef TILE_ACCUM_NAN_FLAG_EN
        nan_acc <= 1'b0;
`endif
      end else begin
        state <= ACCUM;
        acc   <= (state == IDLE) ? in_scal : sum;
        cnt   <= (state == IDLE) ? CNT_W'(1) : cnt_inc;
`ifdef TILE_ACCUM_NAN_FLAG_EN
        nan_acc <= ((state == ACCUM) && nan_acc) || scal_nan;
`endif
      end
    end
  end

  tile_accum_fifo #(.W(E_W), .DEPTH(2)) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (push_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (pop_dat),
    .count  (fifo_cnt),
    .full   (fifo_full)
  );

`ifdef TILE_ACCUM_NAN_FLAG_EN
  assign {out_data, out_count, out_nan} = pop_dat;
`else
  assign {out_data, out_count} = pop_dat;
`endif

  // The in_ready throttle must keep every arriving result from meeting a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !out_ready));
endmodule

// File: tb/tb_tile_accum.sv
module tb_tile_accum;
  localparam int LAT = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_scal = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;
  logic [7:0]  out_count;
`ifdef TILE_ACCUM_NAN_FLAG_EN
  logic        out_nan;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  tile_accum #(.LATENCY(LAT), .CNT_W(8), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .in_scal   (in_scal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
`ifdef TILE_ACCUM_NAN_FLAG_EN
    ,
    .out_nan   (out_nan)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one chunk; the tile model returns scal LAT cycles later. On a last chunk the
  // hand-computed result is queued for the monitor.
  task automatic issue(input logic [15:0] scal, input logic last,
                       input logic [15:0] ed, input logic [7:0] ec, input logic en);
    int waited = 0;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready stuck at 0, needed 1");
      in_valid = 1'b0;
      return;
    end
    if (last) sb.push_back('{d: ed, c: ec, n: en});
    fork
      begin
        automatic logic [15:0] v = scal;
        repeat (LAT) @(posedge clk);
        #1 in_scal = v;
      end
    join_none
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: every accepted output is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got data %0h count %0d, expected no output", out_data, out_count);
      end else begin
        automatic exp_t e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_count", 32'(out_count), 32'(e.c));
`ifdef TILE_ACCUM_NAN_FLAG_EN
        chk("out_nan", 32'(out_nan), 32'(e.n));
`endif
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single chunk: bypass, result visible exactly three cycles after issue.
    issue(16'h3C00, 1'b1, 16'h3C00, 8'd1, 1'b0);
    chk("single_c1_valid", 32'(out_valid), 0);
    chk("single_busy", 32'(busy), 1);
    tick();
    chk("single_c2_valid", 32'(out_valid), 0);
    tick();
    chk("single_c3_valid", 32'(out_valid), 1);
    wait_drain();

    // Three chunks: 1 + 2 + 3 = 6.
    issue(16'h3C00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h4000, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h4200, 1'b1, 16'h4600, 8'd3, 1'b0);
    wait_drain();

    // Mixed signs: 1.0 + (-0.25) = 0.75.
    issue(16'h3C00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'hB400, 1'b1, 16'h3A00, 8'd2, 1'b0);
    wait_drain();
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);

    // Back-pressure: two results fill the budget, a third waits until the consumer drains.
    out_ready = 1'b0;
    issue(16'h3C00, 1'b1, 16'h3C00, 8'd1, 1'b0);
    issue(16'h4000, 1'b1, 16'h4000, 8'd1, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    repeat (4) tick();
    chk("bp_held_ready", 32'(in_ready), 0);
    chk("bp_held_valid", 32'(out_valid), 1);
    fork
      begin
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join_none
    issue(16'h4400, 1'b1, 16'h4400, 8'd1, 1'b0);
    wait_drain();
    tick();
    chk("bp_drained_ready", 32'(in_ready), 1);

    // Back-to-back: 1.0 + 0.5, then a bypassed 0.5 issued the very next cycle.
    issue(16'h3C00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h3800, 1'b1, 16'h3E00, 8'd2, 1'b0);
    issue(16'h3800, 1'b1, 16'h3800, 8'd1, 1'b0);
    wait_drain();

    // Reset mid-accumulation with two chunks still in the tile.
    issue(16'h3C00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h4000, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h4200, 1'b0, 16'h0, 8'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_out_count", 32'(out_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 0);
    issue(16'h3800, 1'b1, 16'h3800, 8'd1, 1'b0);
    wait_drain();

`ifdef TILE_ACCUM_NAN_FLAG_EN
    // NaN on chunk 2 of 3 flags only that result.
    issue(16'h3C00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h7E00, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h4000, 1'b1, 16'h7E00, 8'd3, 1'b1);
    issue(16'h3C00, 1'b1, 16'h3C00, 8'd1, 1'b0);
    wait_drain();
`endif

    // Counter saturation: 260 zero chunks report 255.
    for (int i = 0; i < 259; i++) issue(16'h0000, 1'b0, 16'h0, 8'd0, 1'b0);
    issue(16'h0000, 1'b1, 16'h0000, 8'd255, 1'b0);
    wait_drain();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
